// File: rtl/ssd1963_bus_if.sv
// Avalon-MM request/response bundle between the interconnect and the SSD1963 bus bridge.
// Latency: none (wires only).
// Backpressure: waitrequest from the slave stalls the master.
interface ssd1963_bus_if;
  logic [3:0]  avalon_slave_address;
  logic [3:0]  avalon_slave_byteenable;
  logic        avalon_slave_chipselect;
  logic        avalon_slave_write;
  logic        avalon_slave_read;
  logic [31:0] avalon_slave_writedata;
  logic [31:0] avalon_slave_readdata;
  logic        avalon_slave_waitrequest;

  modport master (
    output avalon_slave_address, avalon_slave_byteenable, avalon_slave_chipselect,
           avalon_slave_write, avalon_slave_read, avalon_slave_writedata,
    input  avalon_slave_readdata, avalon_slave_waitrequest
  );

  modport slave (
    input  avalon_slave_address, avalon_slave_byteenable, avalon_slave_chipselect,
           avalon_slave_write, avalon_slave_read, avalon_slave_writedata,
    output avalon_slave_readdata, avalon_slave_waitrequest
  );
endinterface

// File: rtl/ssd1963_bus.sv
// Avalon-MM slave driving an SSD1963 8080-style bus with programmable setup/strobe/hold.
// Latency: 1+SETUP_CYC+STROBE_CYC+HOLD_CYC cycles to waitrequest low; 1 cycle for lane-less requests.
// Backpressure: waitrequest held high until the DONE cycle. Read path built only with SSD1963_READ_EN.
module ssd1963_bus #(
  parameter int DATA_W     = 8,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  ssd1963_bus_if.slave      avs,
  output logic              cs_n,
  output logic              wr_n,
  output logic              rd_n,
  output logic              dc,
  inout  wire  [DATA_W-1:0] d
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_STROBE = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  // Counters hold "cycles remaining minus one" so state exit happens at zero.
  localparam logic [3:0] CNT_SU = 4'(SETUP_CYC - 1);
  localparam logic [3:0] CNT_ST = 4'(STROBE_CYC - 1);
  localparam logic [3:0] CNT_HO = 4'(HOLD_CYC - 1);

  logic [2:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_cs_n;
  logic              r_wr_n;
  logic              r_dc;
  logic              r_is_wr;
  logic              r_oe;
  logic [DATA_W-1:0] r_wdat;

  logic w_req;
  logic w_wr;
  logic w_lanes;
  logic w_go;
  logic w_unused;

  assign w_req   = avs.avalon_slave_chipselect & (avs.avalon_slave_read | avs.avalon_slave_write);
  // Write wins when the master asserts both read and write.
  assign w_wr    = avs.avalon_slave_write;
  assign w_lanes = (DATA_W == 8) ? avs.avalon_slave_byteenable[0]
                                 : (|avs.avalon_slave_byteenable[1:0]);

`ifdef SSD1963_READ_EN
  logic              r_rd_n;
  logic [DATA_W-1:0] r_rdat;
  assign w_go = w_lanes;
  assign rd_n = r_rd_n;
  assign avs.avalon_slave_readdata = {{(32-DATA_W){1'b0}}, r_rdat};
`else
  // Without the read path every read is answered immediately with zero.
  assign w_go = w_lanes & w_wr;
  assign rd_n = 1'b1;
  assign avs.avalon_slave_readdata = 32'd0;
`endif

  assign cs_n = r_cs_n;
  assign wr_n = r_wr_n;
  assign dc   = r_dc;
  // Output enable only toggles while cs_n or the strobe is high, so no contention with rd_n low.
  assign d    = r_oe ? r_wdat : {DATA_W{1'bz}};

  assign avs.avalon_slave_waitrequest = w_req & (r_state != S_DONE);

  // Only the low address bit and low lanes matter; the rest is intentionally ignored.
  assign w_unused = ^{avs.avalon_slave_address, avs.avalon_slave_byteenable,
                      avs.avalon_slave_writedata};

  // Bus transaction sequencer: every pin is registered and forced idle by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_cs_n  <= 1'b1;
      r_wr_n  <= 1'b1;
      r_dc    <= 1'b0;
      r_is_wr <= 1'b0;
      r_oe    <= 1'b0;
      r_wdat  <= '0;
`ifdef SSD1963_READ_EN
      r_rd_n  <= 1'b1;
      r_rdat  <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_is_wr <= w_wr;
            if (w_go) begin
              r_state <= S_SETUP;
              r_cnt   <= CNT_SU;
              r_cs_n  <= 1'b0;
              r_dc    <= avs.avalon_slave_address[0];
              r_wdat  <= avs.avalon_slave_writedata[DATA_W-1:0];
              r_oe    <= w_wr;
            end else begin
              r_state <= S_DONE;
`ifdef SSD1963_READ_EN
              if (!w_wr) r_rdat <= '0;
`endif
            end
          end
        end
        S_SETUP: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_STROBE;
            r_cnt   <= CNT_ST;
`ifdef SSD1963_READ_EN
            if (r_is_wr) r_wr_n <= 1'b0;
            else         r_rd_n <= 1'b0;
`else
            r_wr_n <= 1'b0;
`endif
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_STROBE: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_HOLD;
            r_cnt   <= CNT_HO;
            r_wr_n  <= 1'b1;
`ifdef SSD1963_READ_EN
            r_rd_n  <= 1'b1;
            // Sample on the edge closing the last strobe cycle.
            if (!r_is_wr) r_rdat <= d;
`endif
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_HOLD: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_DONE;
            r_cs_n  <= 1'b1;
            r_oe    <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ssd1963_bus.sv
// Self-checking bench for ssd1963_bus: three instances (8-bit default, 16-bit, 8-bit 3/4/2 timing).
// Latency: expected completion cycle and readdata are queued per request and compared at waitrequest low.
// Backpressure: the bench master holds its request until it observes waitrequest low.
module tb_ssd1963_bus;

`ifdef SSD1963_READ_EN
  localparam bit RD_EN = 1'b1;
`else
  localparam bit RD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  ssd1963_bus_if if0 ();
  ssd1963_bus_if if1 ();
  ssd1963_bus_if if2 ();

  wire [7:0]  d0;
  wire [7:0]  d2;
  wire [15:0] d1;
  wire [2:0]  p_cs_n, p_wr_n, p_rd_n, p_dc;

  logic [3:0]  q_addr, q_be;
  logic [31:0] q_wd;
  logic        q_cs, q_wr, q_rd;
  int          sel;
  logic        drv_en;
  logic [15:0] drv_dat;

  assign d1 = drv_en ? drv_dat : 16'hzzzz;

  assign if0.avalon_slave_address = q_addr;  assign if0.avalon_slave_byteenable = q_be;
  assign if0.avalon_slave_writedata = q_wd;  assign if0.avalon_slave_write = q_wr;
  assign if0.avalon_slave_read = q_rd;       assign if0.avalon_slave_chipselect = q_cs && (sel == 0);
  assign if1.avalon_slave_address = q_addr;  assign if1.avalon_slave_byteenable = q_be;
  assign if1.avalon_slave_writedata = q_wd;  assign if1.avalon_slave_write = q_wr;
  assign if1.avalon_slave_read = q_rd;       assign if1.avalon_slave_chipselect = q_cs && (sel == 1);
  assign if2.avalon_slave_address = q_addr;  assign if2.avalon_slave_byteenable = q_be;
  assign if2.avalon_slave_writedata = q_wd;  assign if2.avalon_slave_write = q_wr;
  assign if2.avalon_slave_read = q_rd;       assign if2.avalon_slave_chipselect = q_cs && (sel == 2);

  ssd1963_bus #(.DATA_W(8), .SETUP_CYC(1), .STROBE_CYC(2), .HOLD_CYC(1)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .avs(if0),
    .cs_n(p_cs_n[0]), .wr_n(p_wr_n[0]), .rd_n(p_rd_n[0]), .dc(p_dc[0]), .d(d0));
  ssd1963_bus #(.DATA_W(16), .SETUP_CYC(1), .STROBE_CYC(2), .HOLD_CYC(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .avs(if1),
    .cs_n(p_cs_n[1]), .wr_n(p_wr_n[1]), .rd_n(p_rd_n[1]), .dc(p_dc[1]), .d(d1));
  ssd1963_bus #(.DATA_W(8), .SETUP_CYC(3), .STROBE_CYC(4), .HOLD_CYC(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .avs(if2),
    .cs_n(p_cs_n[2]), .wr_n(p_wr_n[2]), .rd_n(p_rd_n[2]), .dc(p_dc[2]), .d(d2));

  // Observation mux for the instance currently under test.
  logic [31:0] m_d, m_rdat;
  logic        m_cs_n, m_wr_n, m_rd_n, m_dc, m_wait;
  always_comb begin
    m_cs_n = p_cs_n[0]; m_wr_n = p_wr_n[0]; m_rd_n = p_rd_n[0]; m_dc = p_dc[0];
    m_d = {24'h0, d0}; m_rdat = if0.avalon_slave_readdata; m_wait = if0.avalon_slave_waitrequest;
    if (sel == 1) begin
      m_cs_n = p_cs_n[1]; m_wr_n = p_wr_n[1]; m_rd_n = p_rd_n[1]; m_dc = p_dc[1];
      m_d = {16'h0, d1}; m_rdat = if1.avalon_slave_readdata; m_wait = if1.avalon_slave_waitrequest;
    end else if (sel == 2) begin
      m_cs_n = p_cs_n[2]; m_wr_n = p_wr_n[2]; m_rd_n = p_rd_n[2]; m_dc = p_dc[2];
      m_d = {24'h0, d2}; m_rdat = if2.avalon_slave_readdata; m_wait = if2.avalon_slave_waitrequest;
    end
  end

  typedef struct {
    int          cyc;
    logic [31:0] rdat;
  } exp_t;
  exp_t sb[$];

  int          dw [3] = '{8, 16, 8};
  int          su [3] = '{1, 1, 3};
  int          st [3] = '{2, 2, 4};
  int          ho [3] = '{1, 1, 2};
  logic [31:0] mrd[3] = '{32'd0, 32'd0, 32'd0};

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] idle_d(input int s);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < dw[s]; i++) v[i] = 1'bz;
    return v;
  endfunction

  // One Avalon transfer with per-cycle pin checks against the timing model.
  task automatic xfer(input int s, input bit w, input bit r, input logic [3:0] a,
                      input logic [3:0] be, input logic [31:0] wd, input logic [15:0] rdv);
    bit          lanes, skip, done, act, stb;
    int          n, busy;
    logic [31:0] er, wexp, mask;
    exp_t        e;
    mask  = (dw[s] == 8) ? 32'h0000_00FF : 32'h0000_FFFF;
    lanes = (dw[s] == 8) ? be[0] : (|be[1:0]);
    skip  = !lanes || (!w && !RD_EN);
    busy  = su[s] + st[s] + ho[s];
    n     = skip ? 1 : 1 + busy;
    if (w)         er = mrd[s];
    else if (skip) er = 32'd0;
    else           er = {16'h0, rdv} & mask;
    mrd[s] = er;
    wexp   = wd & mask;
    sb.push_back('{n, er});

    @(negedge clk);
    sel = s; q_addr = a; q_be = be; q_wd = wd; q_wr = w; q_rd = r; q_cs = 1'b1;
    done = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(posedge clk);
      #1 drv_en = 1'b0;
      #1;
      act = !skip && (c <= busy);
      stb = !skip && (c > su[s]) && (c <= su[s] + st[s]);
      chk("cs_n", {31'd0, m_cs_n}, {31'd0, !act});
      chk("wr_n", {31'd0, m_wr_n}, {31'd0, !(stb && w)});
      chk("rd_n", {31'd0, m_rd_n}, {31'd0, !(stb && !w)});
      if (act) chk("dc", {31'd0, m_dc}, {31'd0, a[0]});
      chk("d", m_d, (act && w) ? wexp : idle_d(s));
      if (!w && stb && s == 1) begin
        drv_dat = rdv;
        drv_en  = 1'b1;
      end
      if (!m_wait) begin
        e = sb.pop_front();
        chk("wait_cyc", c, e.cyc);
        chk("readdata", m_rdat, e.rdat);
        done = 1'b1;
      end
    end
    if (!done) begin
      chk("wait_timeout", {31'd0, m_wait}, 32'd0);
      void'(sb.pop_front());
    end
    @(negedge clk);
    q_cs = 1'b0; q_wr = 1'b0; q_rd = 1'b0; drv_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; drv_en = 1'b0; drv_dat = 16'h0; sel = 0;
    q_addr = 4'h0; q_be = 4'h0; q_wd = 32'h0; q_cs = 1'b0; q_wr = 1'b0; q_rd = 1'b0;
    #22;
    // Reset state
    chk("rst_cs_n", {31'd0, m_cs_n}, 32'd1);
    chk("rst_wr_n", {31'd0, m_wr_n}, 32'd1);
    chk("rst_rd_n", {31'd0, m_rd_n}, 32'd1);
    chk("rst_dc",   {31'd0, m_dc},   32'd0);
    chk("rst_d",    m_d, idle_d(0));
    chk("rst_rdat0", if0.avalon_slave_readdata, 32'd0);
    chk("rst_rdat1", if1.avalon_slave_readdata, 32'd0);
    chk("rst_wait_idle", {31'd0, m_wait}, 32'd0);
    q_cs = 1'b1; q_wr = 1'b1; #1;
    chk("rst_wait_req", {31'd0, m_wait}, 32'd1);
    q_cs = 1'b0; q_wr = 1'b0;
    @(negedge clk); reset_n = 1'b1;

    // 8-bit default timing
    xfer(0, 1'b1, 1'b0, 4'h0, 4'b0001, 32'h0000_002C, 16'h0);
    xfer(0, 1'b1, 1'b0, 4'h1, 4'b0001, 32'hFFFF_FFA5, 16'h0);
    xfer(0, 1'b1, 1'b0, 4'h1, 4'b0000, 32'h0000_0077, 16'h0);
    xfer(0, 1'b1, 1'b0, 4'hE, 4'b1110, 32'h0000_0011, 16'h0);
    xfer(0, 1'b0, 1'b1, 4'h1, 4'b0000, 32'h0, 16'h0);

    // 16-bit: writes, reads, sticky and cleared readdata, read+write priority
    xfer(1, 1'b1, 1'b0, 4'h1, 4'b0010, 32'h1234_5678, 16'h0);
    xfer(1, 1'b0, 1'b1, 4'h1, 4'b0011, 32'h0, 16'hBEEF);
    xfer(1, 1'b1, 1'b0, 4'h0, 4'b0001, 32'h0000_C0DE, 16'h0);
    xfer(1, 1'b0, 1'b1, 4'h1, 4'b1100, 32'h0, 16'h0);
    xfer(1, 1'b0, 1'b1, 4'h0, 4'b0001, 32'h0, 16'h1357);
    xfer(1, 1'b1, 1'b1, 4'h1, 4'b0011, 32'h0000_A55A, 16'h0);

    // 3/4/2 timing sweep
    xfer(2, 1'b1, 1'b0, 4'h1, 4'b0001, 32'h0000_0042, 16'h0);
    xfer(2, 1'b1, 1'b0, 4'h0, 4'b0001, 32'h0000_0081, 16'h0);

    // Reset asserted in the middle of the strobe
    @(negedge clk);
    sel = 0; q_addr = 4'h1; q_be = 4'b0001; q_wd = 32'h0000_003C; q_wr = 1'b1; q_cs = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("mid_wr_n_low", {31'd0, m_wr_n}, 32'd0);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_cs_n", {31'd0, m_cs_n}, 32'd1);
    chk("arst_wr_n", {31'd0, m_wr_n}, 32'd1);
    chk("arst_dc",   {31'd0, m_dc},   32'd0);
    chk("arst_d",    m_d, idle_d(0));
    chk("arst_rdat1", if1.avalon_slave_readdata, 32'd0);
    for (int i = 0; i < 3; i++) mrd[i] = 32'd0;
    @(negedge clk);
    q_cs = 1'b0; q_wr = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    xfer(0, 1'b1, 1'b0, 4'h1, 4'b0001, 32'h0000_005A, 16'h0);
    xfer(1, 1'b0, 1'b1, 4'h1, 4'b0001, 32'h0, 16'h2468);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
